// File: rtl/seg_pkg.sv
// Shared constants for the stopwatch 7-segment scan driver.
// Codes are active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_D0 = 8'hC0;
    localparam logic [7:0] SEG_D1 = 8'hF9;
    localparam logic [7:0] SEG_D2 = 8'hA4;
    localparam logic [7:0] SEG_D3 = 8'hB0;
    localparam logic [7:0] SEG_D4 = 8'h99;
    localparam logic [7:0] SEG_D5 = 8'h92;
    localparam logic [7:0] SEG_D6 = 8'h82;
    localparam logic [7:0] SEG_D7 = 8'hF8;
    localparam logic [7:0] SEG_D8 = 8'h80;
    localparam logic [7:0] SEG_D9 = 8'h90;

    localparam logic [1:0] DIGIT_SEC0 = 2'd0;
    localparam logic [1:0] DIGIT_SEC1 = 2'd1;
    localparam logic [1:0] DIGIT_MIN0 = 2'd2;
    localparam logic [1:0] DIGIT_MIN1 = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code.
// Values above 9 decode to a blank pattern.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] code
);

    always_comb begin
        code = SEG_BLANK;
        case (value)
            4'd0: code = SEG_D0;
            4'd1: code = SEG_D1;
            4'd2: code = SEG_D2;
            4'd3: code = SEG_D3;
            4'd4: code = SEG_D4;
            4'd5: code = SEG_D5;
            4'd6: code = SEG_D6;
            4'd7: code = SEG_D7;
            4'd8: code = SEG_D8;
            4'd9: code = SEG_D9;
            default: code = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment driver with adjust/pause blinking.
// All timing is derived from clock enables on clk.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 250000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       arst_i,
    input  logic [3:0] sec0,
    input  logic [2:0] sec1,
    input  logic [3:0] min0,
    input  logic [2:0] min1,
    input  logic       adj,
    input  logic [1:0] sel,
    input  logic       pause,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_vis;

    logic          scan_tick;
    logic          blink_en;
    logic          blink_wrap;
    logic [3:0]    dig_val;
    logic          dig_ok;
    logic [7:0]    dec_code;
    logic [7:0]    code;
    logic          blink_mask;
    logic          blank;
    logic          dp_lit;
    logic          sel_unused;

    assign sel_unused = sel[1];

    assign scan_tick  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign blink_en   = adj | pause;
    assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));

    // Tens digits are 3 bits wide; 6 and 7 are out of range for them.
    always_comb begin
        dig_val = 4'd0;
        dig_ok  = 1'b1;
        case (digit_idx)
            DIGIT_SEC0: dig_val = sec0;
            DIGIT_SEC1: begin
                dig_val = {1'b0, sec1};
                dig_ok  = (sec1 < 3'd6);
            end
            DIGIT_MIN0: dig_val = min0;
            DIGIT_MIN1: begin
                dig_val = {1'b0, min1};
                dig_ok  = (min1 < 3'd6);
            end
            default: dig_val = 4'd0;
        endcase
    end

    seg7_decode u_dec (
        .value (dig_val),
        .code  (dec_code)
    );

    assign code = dig_ok ? dec_code : SEG_BLANK;

    // Adjust mode overrides pause when choosing which digits blink.
    always_comb begin
        blink_mask = 1'b0;
        if (adj) begin
            if (sel[0])
                blink_mask = (digit_idx == DIGIT_SEC0) ||
                             (digit_idx == DIGIT_SEC1);
            else
                blink_mask = (digit_idx == DIGIT_MIN0) ||
                             (digit_idx == DIGIT_MIN1);
        end else if (pause) begin
            blink_mask = 1'b1;
        end
    end

    assign blank  = blink_mask & ~blink_vis;
    assign dp_lit = (digit_idx == DIGIT_MIN0) && (code != SEG_BLANK);

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_tick) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (blink_wrap) begin
            blink_cnt <= '0;
            blink_vis <= ~blink_vis;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= blank ? SEG_BLANK : {~dp_lit, code[6:0]};
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a scoreboard of predicted {an,seg}.
// Predictions come from elapsed-cycle arithmetic and a reference code table.
module tb_seg_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;

    logic       clk = 1'b0;
    logic       arst_i;
    logic [3:0] sec0;
    logic [2:0] sec1;
    logic [3:0] min0;
    logic [2:0] min1;
    logic       adj;
    logic [1:0] sel;
    logic       pause;
    logic [7:0] seg;
    logic [3:0] an;

    int nchecks = 0;
    int nerr    = 0;
    int k;
    int m;
    logic [11:0] sb[$];

    seg_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk    (clk),
        .arst_i (arst_i),
        .sec0   (sec0),
        .sec1   (sec1),
        .min0   (min0),
        .min1   (min1),
        .adj    (adj),
        .sel    (sel),
        .pause  (pause),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dcode(int v, int lim);
        if (v >= lim) return 8'hFF;
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Output after edge k uses the slot/blink state reached after k-1 edges.
    function automatic logic [11:0] predict();
        int idx;
        bit vis;
        bit msk;
        logic [7:0] c;
        logic [3:0] a;
        idx = ((k - 1) / SCAN_DIV) % 4;
        vis = ((m / BLINK_DIV) % 2) == 0;
        case (idx)
            0: c = dcode(int'(sec0), 10);
            1: c = dcode(int'(sec1), 6);
            2: c = dcode(int'(min0), 10);
            default: c = dcode(int'(min1), 6);
        endcase
        if (adj) msk = sel[0] ? (idx < 2) : (idx >= 2);
        else msk = pause;
        if (msk && !vis) c = 8'hFF;
        else if (idx == 2 && c != 8'hFF) c[7] = 1'b0;
        a = 4'b1111;
        a[idx] = 1'b0;
        return {a, c};
    endfunction

    task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: k=%0d an/seg=%h required %h",
                   tag, k, obs, exp);
        end
    endtask

    task automatic step(string tag, int n);
        logic [11:0] e;
        repeat (n) begin
            sb.push_back(predict());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk(tag, {an, seg}, e);
            k++;
            if (adj | pause) m++;
            else m = 0;
        end
    endtask

    task automatic reset_pulse(string tag);
        arst_i = 1'b1;
        #2;
        chk({tag, "_async"}, {an, seg}, 12'hFFF);
        @(posedge clk);
        #1;
        chk({tag, "_held"}, {an, seg}, 12'hFFF);
        arst_i = 1'b0;
        k = 1;
        m = 0;
    endtask

    initial begin
        arst_i = 1'b1;
        sec0 = 4'd3; sec1 = 3'd5; min0 = 4'd9; min1 = 3'd1;
        adj = 1'b0; sel = 2'b00; pause = 1'b0;
        k = 1;
        m = 0;
        #3;
        chk("reset_init", {an, seg}, 12'hFFF);
        @(posedge clk);
        #1;
        reset_pulse("reset0");

        // scan sequence
        step("scan", 16);
        chk("scan_slot_first", {an, seg}, 12'h7F9);

        // reset mid-slot with digit_idx at 2
        step("scan_pre", 9);
        reset_pulse("reset_mid");
        step("post_reset", 16);

        // adjust seconds, then minutes
        adj = 1'b1; sel = 2'b01;
        step("adj_sec", 64);
        sel = 2'b00;
        step("adj_min", 48);

        adj = 1'b0;
        step("idle", 1);

        // pause blinking, drop pause while blanked
        pause = 1'b1;
        step("pause", 24);
        pause = 1'b0;
        step("unpause", 8);

        // out-of-range digits
        sec0 = 4'hC; min1 = 3'h7;
        step("range", 16);
        sec0 = 4'd7; min1 = 3'd6;
        step("range2", 16);
        sec0 = 4'd0; sec1 = 3'd2; min0 = 4'd4; min1 = 3'd5;

        // blink restart
        pause = 1'b1;
        step("restart_pause", 10);
        pause = 1'b0;
        step("restart_gap", 1);
        adj = 1'b1; sel = 2'b01;
        step("restart_adj", 40);

        // mode change mid-slot
        sel = 2'b10;
        step("sel_hi_unused", 20);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerr);
        $finish;
    end

endmodule
